// File: rtl/loader_pkg.sv
// loader_pkg -- shared definitions for the program loader.
//   state_t    : loader FSM states. CSUM exists only when LOADER_CHECKSUM_EN
//                is defined.
//   WORD_BYTES : bytes per program memory word.
// Optional feature macro: LOADER_CHECKSUM_EN
package loader_pkg;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;
`endif

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// word_assembler -- shifts stream bytes into a 32-bit word, MSB first.
//   clk       : clock
//   rst_n     : asynchronous active-low reset (clears the byte count)
//   clear     : synchronous clear of the byte count
//   shift     : a payload byte is accepted this cycle
//   byte_in   : the accepted byte
//   word      : assembled word, valid in the cycle word_full is high
//   word_full : this cycle's byte completes a word
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shreg_p0;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      shreg_p0 <= {shreg_p0[15:0], byte_in};
    end
  end

  // The fourth byte is still on the input, so the word is completed
  // combinationally and captured downstream in the same cycle.
  assign word      = {shreg_p0, byte_in};
  assign word_full = shift && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// program_loader -- loads a length-prefixed byte stream into program memory
// and holds the core in reset until the load completes.
// Stream: LEN_HI, LEN_LO (big-endian word count), payload words MSB first,
// then one XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_valid/rx_data    : byte stream input; rx_ready accepts a byte
//   start               : re-arms the loader from DONE or ERR
//   mem_we/addr/wdata   : one-cycle word write, addr = BASE_ADDR + 4*index
//   cpu_rst_n           : core reset, released on entry to DONE
//   done / error        : load completed / load aborted
// Optional feature macro: LOADER_CHECKSUM_EN
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEM_BYTES = 8192,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic        accept;
  logic [15:0] len_full;
  logic        data_shift;
  logic        rearm;
  logic        last_word;
  logic [31:0] word_p0;
  logic        word_full_p0;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept     = rx_valid && rx_ready;
  assign len_full   = {len_hi, rx_data};
  assign data_shift = accept && (state == DATA);
  assign rearm      = start && ((state == DONE) || (state == ERR));
  assign last_word  = (word_idx + 16'd1) == len;

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (rearm),
    .shift     (data_shift),
    .byte_in   (rx_data),
    .word      (word_p0),
    .word_full (word_full_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN_HI;
      len_hi    <= 8'd0;
      len       <= 16'd0;
      word_idx  <= 16'd0;
      rx_ready  <= 1'b0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      case (state)
        LEN_HI: begin
          rx_ready <= 1'b1;
          if (accept) begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          rx_ready <= 1'b1;
          if (accept) begin
            len <= len_full;
            if ({16'h0, len_full} > MAX_WORDS) begin
              state    <= ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state     <= CSUM;
`else
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
              rx_ready  <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (data_shift) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (word_full_p0) begin
              word_idx <= word_idx + 16'd1;
              // The write for this last word is issued next cycle by the
              // output register, independent of the state change here.
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state     <= CSUM;
`else
                state     <= DONE;
                done      <= 1'b1;
                cpu_rst_n <= 1'b1;
                rx_ready  <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
          if (start) begin
            state     <= LEN_HI;
            len_hi    <= 8'd0;
            len       <= 16'd0;
            word_idx  <= 16'd0;
            rx_ready  <= 1'b1;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
          end
        end
        default: begin
          state    <= LEN_HI;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: registered memory write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= word_full_p0;
      if (word_full_p0) begin
        mem_addr  <= BASE_ADDR + {46'h0, word_idx, 2'b00};
        mem_wdata <= word_p0;
      end
    end
  end

endmodule
